// File: rtl/uart_rx_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Baud divisors for a 12 MHz system clock, shared by the UART
//            transmitter and receiver, plus small helpers used by the
//            receiver slice.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Clock cycles per serial bit at 12 MHz
    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 313;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;
    localparam int B4800   = 2500;
    localparam int B2400   = 5000;
    localparam int B1200   = 10000;
    localparam int B600    = 20000;
    localparam int B300    = 40000;

    typedef logic [7:0] uart_byte_t;

    // Minimum counter width able to hold the value `baud`
    function automatic int cnt_width(input int baud);
        return $clog2(baud + 1);
    endfunction

    // Map a line rate in bit/s to its divisor; unknown rates fall back to 115200
    function automatic int baud_div(input int rate);
        case (rate)
            300:     return B300;
            600:     return B600;
            1200:    return B1200;
            2400:    return B2400;
            4800:    return B4800;
            9600:    return B9600;
            19200:   return B19200;
            38400:   return B38400;
            57600:   return B57600;
            default: return B115200;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Serial line plus received-byte outputs of the UART receiver.
//            rx   - serial line, idle high, 8N1, LSB first
//            data - last correctly received byte
//            rcv  - one-clk pulse, data newly valid
//            ferr - one-clk pulse, framing error
//            master: line driver / byte consumer; slave: the receiver
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic       rx;
    uart_byte_t data;
    logic       rcv;
    logic       ferr;

    modport master (output rx, input data, input rcv, input ferr);
    modport slave  (input rx, output data, output rcv, output ferr);

endinterface
`default_nettype wire

// File: rtl/uart_rx_baudgen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : baudgen_rx
// Purpose  : Mid-bit tick generator for the UART receiver.
//            clk, rstn - clock, synchronous active-low reset
//            clk_ena   - run the counter; while low it is preloaded
//            half      - preload a BAUD/2 first period instead of BAUD
//            clk_out   - one-clk tick at the end of each period
// Revision : 1.0 - initial release
// ============================================================================
module baudgen_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  wire logic clk,
    input  wire logic rstn,
    input  wire logic clk_ena,
    input  wire logic half,
    output logic      clk_out
);

    localparam int W = cnt_width(BAUD);
    localparam logic [W-1:0] c_FULL_M1 = W'(BAUD - 1);
    localparam logic [W-1:0] c_HALF_M1 = W'(BAUD / 2 - 1);

    logic [W-1:0] r_cnt;

    // Counting down to zero gives exactly BAUD (or BAUD/2) cycles per tick
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (!clk_ena) begin
            r_cnt <= half ? c_HALF_M1 : c_FULL_M1;
        end else if (r_cnt == '0) begin
            r_cnt <= c_FULL_M1;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign clk_out = clk_ena && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with mid-bit sampling and framing-error flag.
//            clk  - system clock
//            rstn - synchronous active-low reset
//            bus  - uart_rx_if.slave: rx in; data, rcv, ferr out
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  wire logic  clk,
    input  wire logic  rstn,
    uart_rx_if.slave   bus
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_IDLE = 3'd4;

    logic [1:0] r_sync;
    logic [2:0] r_state;
    logic [2:0] r_bitcnt;
    uart_byte_t r_shift;
    uart_byte_t r_data;
    logic       r_rcv;
    logic       r_ferr;

    logic w_rx_r;
    logic w_tick;
    logic w_ena;
    logic w_half;

    assign w_rx_r = r_sync[1];
    assign w_ena  = (r_state == c_START) || (r_state == c_DATA) || (r_state == c_STOP);
    // Preload the half period while idle so the first tick lands mid start bit
    assign w_half = (r_state == c_IDLE);

    baudgen_rx #(
        .BAUD    (BAUD)
    ) u_baudgen (
        .clk     (clk),
        .rstn    (rstn),
        .clk_ena (w_ena),
        .half    (w_half),
        .clk_out (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync   <= 2'b11;
            r_state  <= c_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_rcv    <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], bus.rx};
            r_rcv  <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (!w_rx_r) begin
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (w_tick) begin
                        // Line high again at mid start bit: treat as a glitch
                        if (w_rx_r) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_state  <= c_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                end
                c_DATA: begin
                    if (w_tick) begin
                        r_shift  <= {w_rx_r, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= c_STOP;
                        end
                    end
                end
                c_STOP: begin
                    // Returning to IDLE at mid stop leaves half a bit to
                    // catch a directly following start edge
                    if (w_tick) begin
                        if (w_rx_r) begin
                            r_data  <= r_shift;
                            r_rcv   <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= c_WAIT_IDLE;
                        end
                    end
                end
                c_WAIT_IDLE: begin
                    if (w_rx_r) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.data = r_data;
    assign bus.rcv  = r_rcv;
    assign bus.ferr = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx at 115200 and 19200 divisors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int c_FAST = B115200;
    localparam int c_SLOW = baud_div(19200);

    logic clk;
    logic rstn;
    int   cyc;

    int checks;
    int failures;

    logic [7:0] exp_q[$];
    int rcv_cnt;
    int ferr_cnt;
    int last_rcv_cyc;
    int slow_rcv_cnt;
    int slow_last_cyc;
    logic [7:0] slow_last_data;

    uart_rx_if bus();
    uart_rx_if bus2();

    uart_rx #(.BAUD(c_FAST)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    uart_rx #(.BAUD(c_SLOW)) u_dut_slow (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fast DUT scoreboard: each rcv pulse pops one expected byte
    always @(negedge clk) begin
        if (bus.rcv && bus.ferr) begin
            checks++;
            failures++;
            $display("FAIL excl: rcv=%0b ferr=%0b both high, required not both", bus.rcv, bus.ferr);
        end
        if (bus.rcv) begin
            rcv_cnt++;
            last_rcv_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rcv: data=%02h with no frame expected", bus.data);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                if (bus.data !== e) begin
                    failures++;
                    $display("FAIL rcv_data: got %02h required %02h", bus.data, e);
                end
            end
        end
        if (bus.ferr) ferr_cnt++;
        if (bus2.rcv) begin
            slow_rcv_cnt++;
            slow_last_cyc  = cyc;
            slow_last_data = bus2.data;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit slow, output int t0);
        logic [9:0] bits;
        int baud;
        bits = {stop_bit, b, 1'b0};
        baud = slow ? c_SLOW : c_FAST;
        @(posedge clk); #1;
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            if (slow) bus2.rx = bits[i];
            else      bus.rx  = bits[i];
            repeat (baud) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got %02h required 00", bus.data);
        end
        checks++;
        if (bus.rcv !== 1'b0 || bus.ferr !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses: rcv=%0b ferr=%0b required 0 0", bus.rcv, bus.ferr);
        end
        checks++;
        if (bus2.data !== 8'h00) begin
            failures++;
            $display("FAIL reset_slow_data: got %02h required 00", bus2.data);
        end
        rstn = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_frame_k;
        int t0, r0, f0, lat;
        r0 = rcv_cnt; f0 = ferr_cnt;
        exp_q.push_back(8'h4B);
        send_frame(8'h4B, 1'b1, 1'b0, t0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rcv_cnt - r0 != 1 || ferr_cnt != f0) begin
            failures++;
            $display("FAIL k_count: rcv=%0d ferr=%0d required 1 0", rcv_cnt - r0, ferr_cnt - f0);
        end
        lat = last_rcv_cyc - t0;
        checks++;
        if (lat < 989 || lat > 993) begin
            failures++;
            $display("FAIL k_latency: got %0d clk required 989..993", lat);
        end
    endtask

    task automatic test_glitch;
        int r0, f0;
        r0 = rcv_cnt; f0 = ferr_cnt;
        @(posedge clk); #1;
        bus.rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        bus.rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks++;
        if (u_dut.r_state !== 3'd0) begin
            failures++;
            $display("FAIL glitch_idle: state=%0d required 0", u_dut.r_state);
        end
        repeat (1100) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rcv_cnt != r0 || ferr_cnt != f0) begin
            failures++;
            $display("FAIL glitch_pulses: rcv=%0d ferr=%0d required 0 0", rcv_cnt - r0, ferr_cnt - f0);
        end
    endtask

    task automatic test_ferr;
        int t0, r0, f0;
        r0 = rcv_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 1'b0, t0);
        // Line stays low after the bad stop bit
        repeat (3000) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ferr_cnt - f0 != 1 || rcv_cnt != r0) begin
            failures++;
            $display("FAIL ferr_count: ferr=%0d rcv=%0d required 1 0", ferr_cnt - f0, rcv_cnt - r0);
        end
        checks++;
        if (bus.data !== 8'h4B) begin
            failures++;
            $display("FAIL ferr_data_hold: got %02h required 4b", bus.data);
        end
        bus.rx = 1'b1;
        repeat (300) @(posedge clk);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, t0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ferr_cnt - f0 != 1 || rcv_cnt - r0 != 1) begin
            failures++;
            $display("FAIL ferr_recover: ferr=%0d rcv=%0d required 1 1", ferr_cnt - f0, rcv_cnt - r0);
        end
    endtask

    task automatic test_back_to_back;
        int t0, r0, f0;
        r0 = rcv_cnt; f0 = ferr_cnt;
        for (int n = 0; n < 5; n++) begin
            exp_q.push_back(8'h4B);
            send_frame(8'h4B, 1'b1, 1'b0, t0);
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rcv_cnt - r0 != 5 || ferr_cnt != f0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count: rcv=%0d ferr=%0d pending=%0d required 5 0 0",
                     rcv_cnt - r0, ferr_cnt - f0, exp_q.size());
        end
    endtask

    task automatic test_reset_midframe;
        int t0, r0, f0;
        r0 = rcv_cnt; f0 = ferr_cnt;
        fork
            send_frame(8'hF5, 1'b1, 1'b0, t0);
            begin
                // Lands inside data bit 4, whose line level is 1 as are all later bits
                repeat (572) @(posedge clk);
                #2;
                rstn = 1'b0;
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (bus.data !== 8'h00 || bus.rcv !== 1'b0 || bus.ferr !== 1'b0) begin
                    failures++;
                    $display("FAIL midreset_outputs: data=%02h rcv=%0b ferr=%0b required 00 0 0",
                             bus.data, bus.rcv, bus.ferr);
                end
                rstn = 1'b1;
            end
        join
        repeat (200) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rcv_cnt != r0 || ferr_cnt != f0) begin
            failures++;
            $display("FAIL midreset_pulses: rcv=%0d ferr=%0d required 0 0", rcv_cnt - r0, ferr_cnt - f0);
        end
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, 1'b0, t0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rcv_cnt - r0 != 1 || bus.data !== 8'hA3) begin
            failures++;
            $display("FAIL midreset_next: rcv=%0d data=%02h required 1 a3", rcv_cnt - r0, bus.data);
        end
    endtask

    task automatic test_slow_baud;
        int t0, r0, fr0, lat;
        r0 = slow_rcv_cnt; fr0 = rcv_cnt;
        send_frame(8'h4B, 1'b1, 1'b1, t0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (slow_rcv_cnt - r0 != 1 || slow_last_data !== 8'h4B) begin
            failures++;
            $display("FAIL slow_frame: rcv=%0d data=%02h required 1 4b", slow_rcv_cnt - r0, slow_last_data);
        end
        lat = slow_last_cyc - t0;
        checks++;
        if (lat < c_SLOW / 2 + 9 * c_SLOW + 1 || lat > c_SLOW / 2 + 9 * c_SLOW + 5) begin
            failures++;
            $display("FAIL slow_latency: got %0d clk required %0d", lat, c_SLOW / 2 + 9 * c_SLOW + 3);
        end
        checks++;
        if (rcv_cnt != fr0) begin
            failures++;
            $display("FAIL slow_isolation: fast rcv=%0d required 0", rcv_cnt - fr0);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rcv_cnt = 0; ferr_cnt = 0; last_rcv_cyc = 0;
        slow_rcv_cnt = 0; slow_last_cyc = 0; slow_last_data = 8'h00;
        bus.rx  = 1'b1;
        bus2.rx = 1'b1;
        rstn    = 1'b0;
        test_reset();
        test_frame_k();
        test_glitch();
        test_ferr();
        test_back_to_back();
        test_reset_midframe();
        test_slow_baud();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d bytes never received, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
